// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: the renamed uop bundle, queue entry
// layout and default sizing.
package alu_issue_queue_pkg;

    localparam int IQ_DEPTH  = 8;
    localparam int IQ_PRF_W  = 6;
    localparam int IQ_N_WAKE = 4;
    localparam int IQ_ROB_W  = 6;

    typedef enum logic [3:0] {
        ADD_U  = 4'd0,
        SUB_U  = 4'd1,
        AND_U  = 4'd2,
        OR_U   = 4'd3,
        XOR_U  = 4'd4,
        SLT_U  = 4'd5,
        SLL_U  = 4'd6,
        SRL_U  = 4'd7,
        LUI_U  = 4'd8,
        MTC0_U = 4'd9,
        MFC0_U = 4'd10
    } alu_type_e;

    typedef struct packed {
        logic [IQ_ROB_W-1:0] rob_idx;
        logic [IQ_PRF_W-1:0] dst_paddr;
        logic [IQ_PRF_W-1:0] op0_paddr;
        logic [IQ_PRF_W-1:0] op1_paddr;
        logic                op0_re;
        logic                op1_re;
        alu_type_e           alu_type;
    } uop_bundle_t;

    typedef struct packed {
        uop_bundle_t uop;
        logic        rdy0;
        logic        rdy1;
    } iq_entry_t;

    // CP0 class uops need the CP0 port that only ALU0 owns
    function automatic logic is_cp0(input alu_type_e t);
        return (t == MTC0_U) || (t == MFC0_U);
    endfunction

endpackage

// File: rtl/alu_issue_queue_select.sv
// Two-pick age-ordered select: pipe 0 takes the oldest eligible entry (CP0
// only from the head), pipe 1 the next oldest non-CP0 entry.
module iq_select
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic [DEPTH-1:0] eligible,
    input  logic [DEPTH-1:0] cp0_mask,
    output logic [DEPTH-1:0] grant0,
    output logic             grant0_valid,
    output logic [DEPTH-1:0] grant1,
    output logic             grant1_valid
);

    localparam logic [DEPTH-1:0] ONE_V = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0] cand0_s;
    logic [DEPTH-1:0] cand1_s;

    function automatic logic [DEPTH-1:0] first_set(input logic [DEPTH-1:0] v);
        return v & (~v + ONE_V);
    endfunction

    // candidate masks and lowest-index (oldest) grants per pipe
    always_comb begin
        cand0_s      = eligible & ~(cp0_mask & ~ONE_V);
        grant0       = first_set(cand0_s);
        grant0_valid = |cand0_s;
        cand1_s      = eligible & ~cp0_mask & ~grant0;
        grant1       = first_set(cand1_s);
        grant1_valid = |cand1_s;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing issue queue feeding the two ALU pipes; tracks operand readiness
// through wakeup tags and issues up to two oldest-ready uops per cycle.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PRF_W  = IQ_PRF_W,
    parameter int N_WAKE = IQ_N_WAKE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [1:0]                        enq_valid,
    input  uop_bundle_t [1:0]                 enq_uop,
    input  logic [1:0][1:0]                   enq_src_rdy,
    output logic                              enq_ready,
    input  logic [N_WAKE-1:0]                 wake_en,
    input  logic [N_WAKE-1:0][PRF_W-1:0]      wake_tag,
    output logic [1:0]                        iss_valid,
    output uop_bundle_t [1:0]                 iss_uop,
    input  logic [1:0]                        iss_ready,
    output logic [$clog2(DEPTH):0]            count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int UOP_W = $bits(uop_bundle_t);

    iq_entry_t        entries_r     [DEPTH];
    iq_entry_t        entries_nxt_s [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             enq_ready_r;

    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] eligible_s;
    logic [DEPTH-1:0] cp0_s;
    logic [DEPTH-1:0] grant0_s;
    logic [DEPTH-1:0] grant1_s;
    logic [DEPTH-1:0] remove_s;
    logic             grant0_valid_s;
    logic             grant1_valid_s;
    logic [1:0]       fire_s;
    logic             enq_ok_s;
    logic [UOP_W-1:0] iss_vec_s [2];

    function automatic logic wake_hit(input logic [PRF_W-1:0]               tag,
                                      input logic [N_WAKE-1:0]              en,
                                      input logic [N_WAKE-1:0][PRF_W-1:0]   tags);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < N_WAKE; w++) begin
            hit = hit | (en[w] & (tags[w] == tag));
        end
        return hit;
    endfunction

    // per-entry occupancy, eligibility and CP0 class
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_s[i]    = (CNT_W'(i) < count_r);
            eligible_s[i] = valid_s[i] & entries_r[i].rdy0 & entries_r[i].rdy1;
            cp0_s[i]      = valid_s[i] & is_cp0(entries_r[i].uop.alu_type);
        end
    end

    iq_select #(.DEPTH(DEPTH)) u_select (
        .eligible     (eligible_s),
        .cp0_mask     (cp0_s),
        .grant0       (grant0_s),
        .grant0_valid (grant0_valid_s),
        .grant1       (grant1_s),
        .grant1_valid (grant1_valid_s)
    );

    // one-hot grant muxes onto the issue ports
    always_comb begin
        iss_vec_s[0] = '0;
        iss_vec_s[1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            iss_vec_s[0] = iss_vec_s[0] | (entries_r[i].uop & {UOP_W{grant0_s[i]}});
            iss_vec_s[1] = iss_vec_s[1] | (entries_r[i].uop & {UOP_W{grant1_s[i]}});
        end
    end

    assign iss_valid  = {grant1_valid_s, grant0_valid_s};
    assign iss_uop[0] = uop_bundle_t'(iss_vec_s[0]);
    assign iss_uop[1] = uop_bundle_t'(iss_vec_s[1]);
    assign fire_s     = iss_valid & iss_ready;
    assign remove_s   = (grant0_s & {DEPTH{fire_s[0]}}) | (grant1_s & {DEPTH{fire_s[1]}});
    assign enq_ok_s   = enq_ready_r & ~flush;
    assign enq_ready  = enq_ready_r;
    assign count      = count_r;

    // collapse survivors toward the head, apply wakeups, then append new uops
    always_comb begin : collapse
        logic [CNT_W-1:0] wr_pos;
        for (int j = 0; j < DEPTH; j++) begin
            entries_nxt_s[j]      = entries_r[j];
            entries_nxt_s[j].rdy0 = 1'b0;
            entries_nxt_s[j].rdy1 = 1'b0;
        end
        wr_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_s[i] && !remove_s[i]) begin
                entries_nxt_s[wr_pos[IDX_W-1:0]].uop  = entries_r[i].uop;
                entries_nxt_s[wr_pos[IDX_W-1:0]].rdy0 = entries_r[i].rdy0 |
                    wake_hit(entries_r[i].uop.op0_paddr, wake_en, wake_tag);
                entries_nxt_s[wr_pos[IDX_W-1:0]].rdy1 = entries_r[i].rdy1 |
                    wake_hit(entries_r[i].uop.op1_paddr, wake_en, wake_tag);
                wr_pos = wr_pos + CNT_W'(1);
            end else begin
                wr_pos = wr_pos;
            end
        end
        // enq_ready guarantees two free slots, so wr_pos stays in range here
        for (int s = 0; s < 2; s++) begin
            if (enq_ok_s && enq_valid[s]) begin
                entries_nxt_s[wr_pos[IDX_W-1:0]].uop  = enq_uop[s];
                entries_nxt_s[wr_pos[IDX_W-1:0]].rdy0 = ~enq_uop[s].op0_re | enq_src_rdy[s][0] |
                    wake_hit(enq_uop[s].op0_paddr, wake_en, wake_tag);
                entries_nxt_s[wr_pos[IDX_W-1:0]].rdy1 = ~enq_uop[s].op1_re | enq_src_rdy[s][1] |
                    wake_hit(enq_uop[s].op1_paddr, wake_en, wake_tag);
                wr_pos = wr_pos + CNT_W'(1);
            end else begin
                wr_pos = wr_pos;
            end
        end
        if (flush) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = wr_pos;
        end
    end

    // queue state, occupancy and registered enqueue credit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= '0;
            enq_ready_r <= 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                entries_r[j] <= '0;
            end
        end else begin
            count_r     <= count_nxt_s;
            enq_ready_r <= (count_nxt_s <= CNT_W'(DEPTH - 2));
            entries_r   <= entries_nxt_s;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus random
// traffic compared against an age-ordered queue model.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    localparam int DEPTH  = 8;
    localparam int PRF_W  = 6;
    localparam int N_WAKE = 4;

    logic                         clk;
    logic                         rst_n;
    logic                         flush;
    logic [1:0]                   enq_valid;
    uop_bundle_t [1:0]            enq_uop;
    logic [1:0][1:0]              enq_src_rdy;
    logic                         enq_ready;
    logic [N_WAKE-1:0]            wake_en;
    logic [N_WAKE-1:0][PRF_W-1:0] wake_tag;
    logic [1:0]                   iss_valid;
    uop_bundle_t [1:0]            iss_uop;
    logic [1:0]                   iss_ready;
    logic [3:0]                   count;

    alu_issue_queue #(.DEPTH(DEPTH), .PRF_W(PRF_W), .N_WAKE(N_WAKE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_uop     (enq_uop),
        .enq_src_rdy (enq_src_rdy),
        .enq_ready   (enq_ready),
        .wake_en     (wake_en),
        .wake_tag    (wake_tag),
        .iss_valid   (iss_valid),
        .iss_uop     (iss_uop),
        .iss_ready   (iss_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        uop_bundle_t uop;
        bit          r0;
        bit          r1;
    } m_ent_t;

    m_ent_t mq[$];
    int     total = 0;
    int     bad   = 0;
    int     rob_next = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic uop_bundle_t make_uop(input logic [PRF_W-1:0] t0, input bit re0,
                                             input logic [PRF_W-1:0] t1, input bit re1,
                                             input alu_type_e ty);
        uop_bundle_t u;
        u.rob_idx   = 6'(rob_next);
        u.dst_paddr = 6'(rob_next + 17);
        u.op0_paddr = t0;
        u.op1_paddr = t1;
        u.op0_re    = re0;
        u.op1_re    = re1;
        u.alu_type  = ty;
        rob_next++;
        return u;
    endfunction

    function automatic bit woke(input logic [PRF_W-1:0] t);
        for (int w = 0; w < N_WAKE; w++)
            if (wake_en[w] && wake_tag[w] == t) return 1'b1;
        return 1'b0;
    endfunction

    // oldest eligible for pipe 0 (CP0 only at head), next oldest non-CP0 for pipe 1
    function automatic void pick(output int p0, output int p1);
        p0 = -1;
        p1 = -1;
        foreach (mq[i]) begin
            if (mq[i].r0 && mq[i].r1) begin
                if (p0 < 0 && (!is_cp0(mq[i].uop.alu_type) || i == 0)) p0 = i;
                else if (p1 < 0 && !is_cp0(mq[i].uop.alu_type)) p1 = i;
            end
        end
    endfunction

    task automatic idle_inputs();
        flush     = 1'b0;
        enq_valid = 2'b00;
        wake_en   = '0;
        iss_ready = 2'b11;
    endtask

    // compare outputs against the model, advance the model, then one clock
    task automatic step();
        int     p0, p1;
        bit     ok;
        m_ent_t e;
        m_ent_t nq[$];
        pick(p0, p1);
        check_eq("iss_valid", 64'(iss_valid), {62'd0, p1 >= 0, p0 >= 0});
        if (p0 >= 0) check_eq("iss_uop0", 64'(iss_uop[0]), 64'(mq[p0].uop));
        if (p1 >= 0) check_eq("iss_uop1", 64'(iss_uop[1]), 64'(mq[p1].uop));
        check_eq("count", 64'(count), 64'(mq.size()));
        ok = (DEPTH - mq.size()) >= 2;
        check_eq("enq_ready", 64'(enq_ready), 64'(ok));
        if (flush) begin
            mq.delete();
        end else begin
            foreach (mq[i]) begin
                if (!((i == p0 && iss_ready[0]) || (i == p1 && iss_ready[1]))) begin
                    e = mq[i];
                    e.r0 = e.r0 | woke(e.uop.op0_paddr);
                    e.r1 = e.r1 | woke(e.uop.op1_paddr);
                    nq.push_back(e);
                end
            end
            if (ok) begin
                for (int s = 0; s < 2; s++) begin
                    if (enq_valid[s]) begin
                        e.uop = enq_uop[s];
                        e.r0  = !enq_uop[s].op0_re || enq_src_rdy[s][0] || woke(enq_uop[s].op0_paddr);
                        e.r1  = !enq_uop[s].op1_re || enq_src_rdy[s][1] || woke(enq_uop[s].op1_paddr);
                        nq.push_back(e);
                    end
                end
            end
            mq = nq;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        flush = ($urandom_range(0, 39) == 0);
        for (int s = 0; s < 2; s++) begin
            alu_type_e ty;
            if ($urandom_range(0, 5) == 0) ty = ($urandom_range(0, 1) == 0) ? MTC0_U : MFC0_U;
            else ty = alu_type_e'(4'($urandom_range(0, 8)));
            enq_valid[s]   = ($urandom_range(0, 2) != 0);
            enq_uop[s]     = make_uop(6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                                      6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ty);
            enq_src_rdy[s] = 2'($urandom_range(0, 3));
        end
        if ((DEPTH - mq.size()) < 2 && $urandom_range(0, 7) != 0) enq_valid = 2'b00;
        wake_en = 4'($urandom_range(0, 15));
        for (int w = 0; w < N_WAKE; w++) wake_tag[w] = 6'($urandom_range(0, 15));
        iss_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
    endtask

    initial begin
        rst_n       = 1'b0;
        enq_uop     = '0;
        enq_src_rdy = '0;
        wake_tag    = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_iss_valid", 64'(iss_valid), 64'd0);
        check_eq("rst_enq_ready", 64'(enq_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // two ready ADDs in one cycle, both issue next cycle
        enq_valid   = 2'b11;
        enq_uop[0]  = make_uop(6'd1, 1'b1, 6'd2, 1'b1, ADD_U);
        enq_uop[1]  = make_uop(6'd3, 1'b1, 6'd4, 1'b0, ADD_U);
        enq_src_rdy = 4'b1111;
        step();
        idle_inputs();
        repeat (2) step();

        // A waits on tag 12, B ready; wake on port 1
        enq_valid   = 2'b11;
        enq_uop[0]  = make_uop(6'd12, 1'b1, 6'd5, 1'b0, SUB_U);
        enq_uop[1]  = make_uop(6'd6, 1'b1, 6'd7, 1'b1, OR_U);
        enq_src_rdy = 4'b1110;
        step();
        idle_inputs();
        step();
        wake_en     = 4'b0010;
        wake_tag[1] = 6'd12;
        step();
        idle_inputs();
        repeat (2) step();

        // fill eight waiting entries, then wake everything
        for (int c = 0; c < 4; c++) begin
            enq_valid   = 2'b11;
            enq_uop[0]  = make_uop(6'(32 + 2 * c), 1'b1, 6'd0, 1'b0, ADD_U);
            enq_uop[1]  = make_uop(6'(33 + 2 * c), 1'b1, 6'd0, 1'b0, XOR_U);
            enq_src_rdy = 4'b0000;
            step();
        end
        idle_inputs();
        step();
        for (int c = 0; c < 2; c++) begin
            wake_en = 4'b1111;
            for (int w = 0; w < N_WAKE; w++) wake_tag[w] = 6'(32 + 4 * c + w);
            step();
        end
        idle_inputs();
        repeat (5) step();

        // MTC0 behind a blocked head
        enq_valid   = 2'b11;
        enq_uop[0]  = make_uop(6'd50, 1'b1, 6'd0, 1'b0, AND_U);
        enq_uop[1]  = make_uop(6'd8, 1'b0, 6'd9, 1'b0, MTC0_U);
        enq_src_rdy = 4'b0000;
        step();
        idle_inputs();
        repeat (2) step();
        wake_en     = 4'b0100;
        wake_tag[2] = 6'd50;
        step();
        idle_inputs();
        repeat (3) step();

        // pipe 0 stalled while pipe 1 drains
        enq_valid   = 2'b11;
        enq_uop[0]  = make_uop(6'd1, 1'b0, 6'd1, 1'b0, ADD_U);
        enq_uop[1]  = make_uop(6'd1, 1'b0, 6'd1, 1'b0, SLT_U);
        enq_src_rdy = 4'b0000;
        step();
        enq_valid   = 2'b01;
        enq_uop[0]  = make_uop(6'd1, 1'b0, 6'd1, 1'b0, SLL_U);
        step();
        idle_inputs();
        iss_ready = 2'b10;
        repeat (3) step();
        idle_inputs();
        repeat (2) step();

        // flush together with enqueue and issue
        enq_valid   = 2'b11;
        enq_uop[0]  = make_uop(6'd1, 1'b0, 6'd1, 1'b0, ADD_U);
        enq_uop[1]  = make_uop(6'd1, 1'b0, 6'd1, 1'b0, ADD_U);
        step();
        enq_uop[0]  = make_uop(6'd1, 1'b0, 6'd1, 1'b0, ADD_U);
        enq_uop[1]  = make_uop(6'd1, 1'b0, 6'd1, 1'b0, ADD_U);
        flush       = 1'b1;
        step();
        idle_inputs();
        step();

        // asynchronous reset in the middle of a fill
        enq_valid   = 2'b11;
        enq_uop[0]  = make_uop(6'd60, 1'b1, 6'd0, 1'b0, ADD_U);
        enq_uop[1]  = make_uop(6'd61, 1'b1, 6'd0, 1'b0, ADD_U);
        enq_src_rdy = 4'b0000;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_count", 64'(count), 64'd0);
        check_eq("async_rst_iss_valid", 64'(iss_valid), 64'd0);
        mq.delete();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Collapsing 8-entry issue queue that schedules renamed ALU micro-ops onto the two ALU pipes (ALU0, ALU1). It sits between rename/dispatch and the ALU register-read stage. It tracks operand readiness by physical-register wakeup tags and selects up to two oldest-ready uops per cycle. ALU_CP0 uops are pinned to ALU0, which owns the CP0 read/write port, and are serialized at the queue head.

## Interface
Parameters:
- DEPTH, 8: queue entries; power of two, at least 4.
- PRF_W, 6: physical register tag width.
- N_WAKE, 4: wakeup broadcast ports. Ports 0/1 carry the ALU0/ALU1 bypasses; ports 2/3 carry the LSU and MDU.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush (mispredict/exception); empties the queue.
- enq_valid  in  2  dispatch slot valids; slot 0 is older.
- enq_uop  in  2×UOPBundle  dispatched uops; the block uses op0PAddr, op1PAddr, op0re, op1re and aluType.
- enq_src_rdy  in  2×2  per slot, {src1,src0} ready from the busy table.
- enq_ready  out  1  high when free entries ≥ 2.
- wake_en  in  N_WAKE  tag-broadcast valid.
- wake_tag  in  N_WAKE×PRF_W  broadcast physical destination tags.
- iss_valid  out  2  pipe k has a selected uop.
- iss_uop  out  2×UOPBundle  selected uop for pipe k.
- iss_ready  in  2  pipe k accepts this cycle.
- count  out  $clog2(DEPTH)+1  occupied entries, for debug and perf counters.

## Operation
- Storage: entries[0..DEPTH-1], ordered oldest at index 0. Each entry holds {uop, rdy0, rdy1}, and `count` gives occupancy. Entry fields are don't-care at reset. Only `count` and the rdy bits need reset.
- Source readiness: an operand with opNre=0 is ready on enqueue. Otherwise it is ready if enq_src_rdy is set, or any wake_en[i] with wake_tag[i]==opNPAddr in the same cycle.
- Wakeup: each cycle, every valid entry sets rdyN when any enabled wake_tag matches opNPAddr. Set bits stay set.
- Eligible: the entry is valid and rdy0 & rdy1 are both set.
- Pipe 0 selection: the oldest eligible entry.
  - An ALU_CP0 entry is eligible for pipe 0 only at index 0.
- Pipe 1 selection: the oldest eligible entry other than pipe 0's pick, excluding ALU_CP0.
- Selection does not depend on iss_ready. An entry is removed only on iss_valid[k] & iss_ready[k].
  - If pipe 0 stalls, its entry remains. Pipe 1 may still issue its own pick.
- Collapse: survivors shift toward index 0 in original order. New uops append after the survivors, slot 0 before slot 1.
  - If only enq_valid[1] is set, it fills the next free entry alone.
- Enqueue: enqueue while enq_ready=0 is a protocol error. Dispatch must not assert enq_valid in that case. The block ignores such an enqueue.
- Flush: count becomes 0 at the next edge. Issues and enqueues in the flush cycle are discarded, so the next cycle has iss_valid=0.

## Timing
- Reset: count=0, iss_valid=0, enq_ready=1, all rdy bits 0.
- Enqueue latency: a uop enqueued with both sources ready at edge t can issue (iss_valid=1) in cycle t+1.
- Wakeup latency: a wake pulse in cycle t makes a waiting entry eligible in cycle t+1. There is no same-cycle wake-to-issue path.
- Output path: iss_* are combinational from registered queue state. There is no combinational path from iss_ready, wake_* or enq_* to iss_*.
- Simultaneous events: issue of 2, enqueue of 2 and wakeup can all occur in one cycle. The next-state count is count − issued + enqueued.
- enq_ready: computed from registered count (DEPTH − count ≥ 2). It does not take credit for same-cycle issue.
- Full and empty: at count=DEPTH, enq_ready=0 and entries still issue. At count=0, iss_valid=0.

## Structure
- Shared defs package: typedef IQEntry {UOPBundle uop; logic rdy0, rdy1;} and localparam IQ_DEPTH.
- Sub-module iq_select: takes a DEPTH-bit eligible vector plus a head-only CP0 mask. It returns two one-hot grants (first and second set bit) and their valid flags.
- The top level holds the entry registers, the wakeup comparators (DEPTH×2×N_WAKE), the collapse mux, and the enqueue/flush control.

## Test plan
- Reset, then enqueue 2 ready ADD_U uops in one cycle → the next cycle has iss_valid=2'b11, older uop on pipe 0, and count returns to 0 after the handshake.
- Enqueue A with op0PAddr=12 not ready, then B ready → B issues on pipe 0 first. After wake_tag[1]=12, A issues exactly one cycle later.
- Fill 8 entries with uops whose sources are not ready → enq_ready=0 at count=7 and at count=8. Wake all tags → two issue per cycle in age order, 4 cycles to empty.
- MTC0_U at index 1 behind a blocked entry → not issued on either pipe. Once it reaches index 0 it issues on pipe 0 only.
- iss_ready=2'b10 for 3 cycles with 3 ready uops → pipe 0's pick is held stable on iss_uop[0]. Pipe 1 drains the younger two.
- flush in the same cycle as enqueue 2 and issue 2 → count=0 and iss_valid=0 next cycle. Assert rst_n low mid-fill → count=0 immediately (asynchronously).
